// File: rtl/nexys_starship_ssd_scan_if.sv
// Frame-load bus between game logic (master) and the seven-segment scan controller (slave).
interface nexys_starship_ssd_scan_if #(
    parameter int N_DIGITS = 8
);
    logic [4*N_DIGITS-1:0] digits_in;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   blank_in;
    logic [N_DIGITS-1:0]   blink_in;
    logic                  load;
    logic                  load_pending;

    modport master (
        output digits_in, dp_in, blank_in, blink_in, load,
        input  load_pending
    );

    modport slave (
        input  digits_in, dp_in, blank_in, blink_in, load,
        output load_pending
    );
endinterface

// File: rtl/nexys_starship_ssd_scan.sv
// N-digit multiplexed seven-segment scan controller with a double-buffered frame that commits at frame boundaries.
// Optional build macro SSD_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module nexys_starship_ssd_scan #(
    parameter int N_DIGITS       = 8,
    parameter int SCAN_DIV_BITS  = 18,
    parameter int DEADTIME       = 4,
    parameter int BLINK_DIV_BITS = 25,
    localparam int CW            = $clog2(N_DIGITS)
) (
    input  logic                     board_clk,
    input  logic                     Reset,
    nexys_starship_ssd_scan_if.slave bus,
    output logic                     frame_done,
    output logic [CW-1:0]            cur_digit,
    output logic [N_DIGITS-1:0]      anodes,
    output logic [7:0]               cathodes
);

    localparam logic [SCAN_DIV_BITS-1:0] PRESC_MAX  = {SCAN_DIV_BITS{1'b1}};
    localparam logic [SCAN_DIV_BITS-1:0] DEAD_END   = SCAN_DIV_BITS'(DEADTIME);
    localparam logic [CW-1:0]            LAST_DIGIT = CW'(N_DIGITS - 1);

    // Active-low {a,b,c,d,e,f,g} pattern for a hex nibble.
    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

`ifdef SSD_LEADING_ZERO_BLANK_EN
    // Zero digits above the most significant non-zero digit; digit 0 always shows.
    function automatic logic [N_DIGITS-1:0] lz_mask(input logic [4*N_DIGITS-1:0] d);
        logic                seen;
        logic [N_DIGITS-1:0] m;
        seen = 1'b0;
        m    = {N_DIGITS{1'b0}};
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            if (!seen && (d[4*i +: 4] == 4'h0)) begin
                m[i] = 1'b1;
            end else begin
                seen = 1'b1;
            end
        end
        return m;
    endfunction
`endif

    logic [SCAN_DIV_BITS-1:0]  presc_q, presc_d;
    logic [CW-1:0]             cur_q, cur_d;
    logic [BLINK_DIV_BITS-1:0] blink_cnt_q, blink_cnt_d;
    logic [4*N_DIGITS-1:0]     stg_digits_q, stg_digits_d, act_digits_q, act_digits_d;
    logic [N_DIGITS-1:0]       stg_dp_q, stg_dp_d, act_dp_q, act_dp_d;
    logic [N_DIGITS-1:0]       stg_blank_q, stg_blank_d, act_blank_q, act_blank_d;
    logic [N_DIGITS-1:0]       stg_blink_q, stg_blink_d, act_blink_q, act_blink_d;
    logic                      load_pending_q, load_pending_d;
    logic                      frame_done_q, frame_done_d;
    logic [N_DIGITS-1:0]       anodes_q, anodes_d;
    logic [7:0]                cathodes_q, cathodes_d;

    logic                      slot_wrap_s, boundary_s;
    logic [N_DIGITS-1:0]       lz_supp_s;
    logic [3:0]                cur_nib_s;
    logic                      cur_dp_s, cur_blank_s, cur_blink_s, cur_supp_s, lit_s;

    // Scan timing, frame staging/commit and next-state of all registers.
    always_comb begin
        presc_d     = presc_q + SCAN_DIV_BITS'(1);
        blink_cnt_d = blink_cnt_q + BLINK_DIV_BITS'(1);
        slot_wrap_s = (presc_q == PRESC_MAX);
        boundary_s  = slot_wrap_s && (cur_q == LAST_DIGIT);

        if (slot_wrap_s) begin
            if (cur_q == LAST_DIGIT) begin
                cur_d = {CW{1'b0}};
            end else begin
                cur_d = cur_q + CW'(1);
            end
        end else begin
            cur_d = cur_q;
        end

        // High throughout the last cycle of a frame, i.e. the cycle whose edge returns cur_digit to 0.
        frame_done_d = (presc_d == PRESC_MAX) && (cur_d == LAST_DIGIT);

        stg_digits_d   = stg_digits_q;
        stg_dp_d       = stg_dp_q;
        stg_blank_d    = stg_blank_q;
        stg_blink_d    = stg_blink_q;
        act_digits_d   = act_digits_q;
        act_dp_d       = act_dp_q;
        act_blank_d    = act_blank_q;
        act_blink_d    = act_blink_q;
        load_pending_d = load_pending_q;

        if (boundary_s) begin
            if (bus.load) begin
                stg_digits_d   = bus.digits_in;
                stg_dp_d       = bus.dp_in;
                stg_blank_d    = bus.blank_in;
                stg_blink_d    = bus.blink_in;
                act_digits_d   = bus.digits_in;
                act_dp_d       = bus.dp_in;
                act_blank_d    = bus.blank_in;
                act_blink_d    = bus.blink_in;
                load_pending_d = 1'b0;
            end else if (load_pending_q) begin
                act_digits_d   = stg_digits_q;
                act_dp_d       = stg_dp_q;
                act_blank_d    = stg_blank_q;
                act_blink_d    = stg_blink_q;
                load_pending_d = 1'b0;
            end else begin
                load_pending_d = load_pending_q;
            end
        end else if (bus.load) begin
            stg_digits_d   = bus.digits_in;
            stg_dp_d       = bus.dp_in;
            stg_blank_d    = bus.blank_in;
            stg_blink_d    = bus.blink_in;
            load_pending_d = 1'b1;
        end else begin
            load_pending_d = load_pending_q;
        end
    end

    // Decode the current slot into next anode/cathode values (registered below).
    always_comb begin
`ifdef SSD_LEADING_ZERO_BLANK_EN
        lz_supp_s = lz_mask(act_digits_q);
`else
        lz_supp_s = {N_DIGITS{1'b0}};
`endif
        cur_nib_s   = 4'h0;
        cur_dp_s    = 1'b0;
        cur_blank_s = 1'b1;
        cur_blink_s = 1'b0;
        cur_supp_s  = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (cur_q == CW'(i)) begin
                cur_nib_s   = act_digits_q[4*i +: 4];
                cur_dp_s    = act_dp_q[i];
                cur_blank_s = act_blank_q[i];
                cur_blink_s = act_blink_q[i];
                cur_supp_s  = lz_supp_s[i];
            end else begin
                cur_supp_s = cur_supp_s;
            end
        end

        // A suppressed leading zero still lights when its decimal point is on.
        lit_s = (presc_q >= DEAD_END) && !cur_blank_s
                && !(cur_blink_s && blink_cnt_q[BLINK_DIV_BITS-1])
                && !(cur_supp_s && !cur_dp_s);

        for (int i = 0; i < N_DIGITS; i++) begin
            anodes_d[i] = !(lit_s && (cur_q == CW'(i)));
        end

        if (lit_s) begin
            if (cur_supp_s) begin
                cathodes_d = {7'b1111111, ~cur_dp_s};
            end else begin
                cathodes_d = {hex_seg(cur_nib_s), ~cur_dp_s};
            end
        end else begin
            cathodes_d = 8'hFF;
        end
    end

    // State and output registers; reset darkens the display and drops any pending frame.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            presc_q        <= {SCAN_DIV_BITS{1'b0}};
            cur_q          <= {CW{1'b0}};
            blink_cnt_q    <= {BLINK_DIV_BITS{1'b0}};
            stg_digits_q   <= {(4*N_DIGITS){1'b0}};
            stg_dp_q       <= {N_DIGITS{1'b0}};
            stg_blank_q    <= {N_DIGITS{1'b1}};
            stg_blink_q    <= {N_DIGITS{1'b0}};
            act_digits_q   <= {(4*N_DIGITS){1'b0}};
            act_dp_q       <= {N_DIGITS{1'b0}};
            act_blank_q    <= {N_DIGITS{1'b1}};
            act_blink_q    <= {N_DIGITS{1'b0}};
            load_pending_q <= 1'b0;
            frame_done_q   <= 1'b0;
            anodes_q       <= {N_DIGITS{1'b1}};
            cathodes_q     <= 8'hFF;
        end else begin
            presc_q        <= presc_d;
            cur_q          <= cur_d;
            blink_cnt_q    <= blink_cnt_d;
            stg_digits_q   <= stg_digits_d;
            stg_dp_q       <= stg_dp_d;
            stg_blank_q    <= stg_blank_d;
            stg_blink_q    <= stg_blink_d;
            act_digits_q   <= act_digits_d;
            act_dp_q       <= act_dp_d;
            act_blank_q    <= act_blank_d;
            act_blink_q    <= act_blink_d;
            load_pending_q <= load_pending_d;
            frame_done_q   <= frame_done_d;
            anodes_q       <= anodes_d;
            cathodes_q     <= cathodes_d;
        end
    end

    assign bus.load_pending = load_pending_q;
    assign frame_done       = frame_done_q;
    assign cur_digit        = cur_q;
    assign anodes           = anodes_q;
    assign cathodes         = cathodes_q;

endmodule

// File: tb/tb_nexys_starship_ssd_scan.sv
// Directed bench for nexys_starship_ssd_scan with N_DIGITS=4, SCAN_DIV_BITS=2, DEADTIME=1, BLINK_DIV_BITS=6.
module tb_nexys_starship_ssd_scan;

    logic       board_clk;
    logic       Reset;
    logic       frame_done;
    logic [1:0] cur_digit;
    logic [3:0] anodes;
    logic [7:0] cathodes;

    int n_tests;
    int n_fail;
    int t;

    nexys_starship_ssd_scan_if #(.N_DIGITS(4)) bus_if ();

    nexys_starship_ssd_scan #(
        .N_DIGITS      (4),
        .SCAN_DIV_BITS (2),
        .DEADTIME      (1),
        .BLINK_DIV_BITS(6)
    ) dut (
        .board_clk (board_clk),
        .Reset     (Reset),
        .bus       (bus_if),
        .frame_done(frame_done),
        .cur_digit (cur_digit),
        .anodes    (anodes),
        .cathodes  (cathodes)
    );

    initial board_clk = 1'b0;
    always #5 board_clk = ~board_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge board_clk);
        #1;
        t++;
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h5: return 7'b0100100;
            4'h8: return 7'b0000000;
            4'hA: return 7'b0001000;
            4'hF: return 7'b0111000;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    // Expected {anodes, cathodes} after an edge, given the scan state s (edges since reset, before that edge).
    function automatic logic [11:0] exp_disp(input int s, input logic [15:0] dg, input logic [3:0] dp,
                                             input logic [3:0] bl, input logic [3:0] bk);
        int         presc;
        int         cur;
        logic       ph;
        logic       lit;
        logic [3:0] supp;
        logic [3:0] an;
        logic [7:0] ca;
        presc = s % 4;
        cur   = (s / 4) % 4;
        ph    = ((s >> 5) & 1) != 0;
        supp  = 4'b0000;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        if (dg[15:12] == 4'h0) supp[3] = 1'b1;
        if (supp[3] && dg[11:8] == 4'h0) supp[2] = 1'b1;
        if (supp[2] && dg[7:4] == 4'h0) supp[1] = 1'b1;
`endif
        lit = (presc >= 1) && !bl[cur] && !(bk[cur] && ph) && !(supp[cur] && !dp[cur]);
        an = 4'hF;
        ca = 8'hFF;
        if (lit) begin
            an[cur] = 1'b0;
            ca = {(supp[cur] ? 7'b1111111 : seg_of(dg[4*cur +: 4])), ~dp[cur]};
        end
        return {an, ca};
    endfunction

    task automatic run_check(input int n, input logic [15:0] dg, input logic [3:0] dp,
                             input logic [3:0] bl, input logic [3:0] bk);
        logic [11:0] e;
        for (int k = 0; k < n; k++) begin
            tick();
            e = exp_disp(t - 1, dg, dp, bl, bk);
            check_eq($sformatf("anodes@%0d", t), {28'd0, anodes}, {20'd0, e[11:8]});
            check_eq($sformatf("cathodes@%0d", t), {24'd0, cathodes}, {24'd0, e[7:0]});
        end
    endtask

    task automatic drive_load(input logic [15:0] dg, input logic [3:0] dp, input logic [3:0] bl,
                              input logic [3:0] bk);
        bus_if.digits_in = dg;
        bus_if.dp_in     = dp;
        bus_if.blank_in  = bl;
        bus_if.blink_in  = bk;
        bus_if.load      = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        t       = 0;
        Reset   = 1'b1;
        bus_if.digits_in = 16'h0000;
        bus_if.dp_in     = 4'h0;
        bus_if.blank_in  = 4'h0;
        bus_if.blink_in  = 4'h0;
        bus_if.load      = 1'b0;
        repeat (3) @(posedge board_clk);
        #1;
        check_eq("rst_anodes", {28'd0, anodes}, 32'hF);
        check_eq("rst_cathodes", {24'd0, cathodes}, 32'hFF);
        check_eq("rst_pending", {31'd0, bus_if.load_pending}, 32'd0);
        check_eq("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check_eq("rst_cur_digit", {30'd0, cur_digit}, 32'd0);
        Reset = 1'b0;
        t = 0;

        // 1: dark display, frame_done cadence and slot sequence
        for (int i = 0; i < 64; i++) begin
            tick();
            check_eq($sformatf("idle_anodes@%0d", t), {28'd0, anodes}, 32'hF);
            check_eq($sformatf("idle_cathodes@%0d", t), {24'd0, cathodes}, 32'hFF);
            check_eq($sformatf("idle_frame_done@%0d", t), {31'd0, frame_done}, {31'd0, (t % 16) == 15});
            check_eq($sformatf("idle_cur_digit@%0d", t), {30'd0, cur_digit}, (t / 4) % 4);
        end

        // 2: load 12AF mid-frame; dark until the boundary at edge 80
        drive_load(16'h12AF, 4'b0001, 4'b0000, 4'b0000);
        run_check(1, 16'h0000, 4'h0, 4'hF, 4'h0);
        bus_if.load = 1'b0;
        check_eq("t2_pending_set", {31'd0, bus_if.load_pending}, 32'd1);
        run_check(14, 16'h0000, 4'h0, 4'hF, 4'h0);
        check_eq("t2_pending_before", {31'd0, bus_if.load_pending}, 32'd1);
        check_eq("t2_frame_done", {31'd0, frame_done}, 32'd1);
        run_check(1, 16'h0000, 4'h0, 4'hF, 4'h0);
        check_eq("t2_pending_after", {31'd0, bus_if.load_pending}, 32'd0);
        run_check(2, 16'h12AF, 4'b0001, 4'b0000, 4'b0000);
        check_eq("t2_slot0_cathodes", {24'd0, cathodes}, 32'h70);
        check_eq("t2_slot0_anodes", {28'd0, anodes}, 32'hE);
        run_check(14, 16'h12AF, 4'b0001, 4'b0000, 4'b0000);

        // 3: two loads in one frame; last load wins, 1111 never shown
        drive_load(16'h1111, 4'h0, 4'h0, 4'h0);
        run_check(1, 16'h12AF, 4'b0001, 4'b0000, 4'b0000);
        bus_if.load = 1'b0;
        check_eq("t3_pending_first", {31'd0, bus_if.load_pending}, 32'd1);
        run_check(3, 16'h12AF, 4'b0001, 4'b0000, 4'b0000);
        drive_load(16'h2222, 4'h0, 4'h0, 4'h0);
        run_check(1, 16'h12AF, 4'b0001, 4'b0000, 4'b0000);
        bus_if.load = 1'b0;
        run_check(10, 16'h12AF, 4'b0001, 4'b0000, 4'b0000);
        check_eq("t3_pending_held", {31'd0, bus_if.load_pending}, 32'd1);
        run_check(1, 16'h12AF, 4'b0001, 4'b0000, 4'b0000);
        check_eq("t3_pending_clear", {31'd0, bus_if.load_pending}, 32'd0);
        run_check(15, 16'h2222, 4'h0, 4'h0, 4'h0);

        // 4: load during the frame_done cycle commits directly
        check_eq("t4_frame_done", {31'd0, frame_done}, 32'd1);
        drive_load(16'h8888, 4'h0, 4'h0, 4'h0);
        run_check(1, 16'h2222, 4'h0, 4'h0, 4'h0);
        bus_if.load = 1'b0;
        check_eq("t4_pending_stays0", {31'd0, bus_if.load_pending}, 32'd0);
        run_check(2, 16'h8888, 4'h0, 4'h0, 4'h0);
        check_eq("t4_slot0_cathodes", {24'd0, cathodes}, 32'h01);
        run_check(14, 16'h8888, 4'h0, 4'h0, 4'h0);

        // 5: digit 2 blinks across both blink phases
        drive_load(16'h0300, 4'h0, 4'h0, 4'b0100);
        run_check(1, 16'h8888, 4'h0, 4'h0, 4'h0);
        bus_if.load = 1'b0;
        check_eq("t5_pending", {31'd0, bus_if.load_pending}, 32'd1);
        run_check(15, 16'h8888, 4'h0, 4'h0, 4'h0);
        run_check(64, 16'h0300, 4'h0, 4'h0, 4'b0100);

        // 6: reset mid-slot with a pending load
        drive_load(16'h0050, 4'h0, 4'h0, 4'h0);
        run_check(1, 16'h0300, 4'h0, 4'h0, 4'b0100);
        bus_if.load = 1'b0;
        run_check(1, 16'h0300, 4'h0, 4'h0, 4'b0100);
        check_eq("t6_pending_before", {31'd0, bus_if.load_pending}, 32'd1);
        Reset = 1'b1;
        @(posedge board_clk);
        #1;
        check_eq("t6_rst_anodes", {28'd0, anodes}, 32'hF);
        check_eq("t6_rst_cathodes", {24'd0, cathodes}, 32'hFF);
        check_eq("t6_rst_pending", {31'd0, bus_if.load_pending}, 32'd0);
        check_eq("t6_rst_cur_digit", {30'd0, cur_digit}, 32'd0);
        Reset = 1'b0;
        t = 0;
        drive_load(16'h0050, 4'h0, 4'h0, 4'h0);
        run_check(1, 16'h0000, 4'h0, 4'hF, 4'h0);
        bus_if.load = 1'b0;
        run_check(15, 16'h0000, 4'h0, 4'hF, 4'h0);
        run_check(16, 16'h0050, 4'h0, 4'h0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
